dcache_wr_buffer: RTL and testbench

//  Write buffer between the Dcache AXI-side write port (wr_req/wr_type/wr_addr/wr_wstrb/wr_data/wr_rdy)
//  and the sram-AXI bridge dcache write port. It absorbs dirty-line write-backs and uncached word

---
 rtl/dcache_wr_buffer.sv | 123 ++++++++++++
 tb/tb_dcache_wr_buffer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wr_buffer.sv
// Dcache write buffer: FIFO between the Dcache write port and the AXI bridge, with a
// same-line read-hazard gate. Optional same-cycle bypass when empty: WBUF_BYPASS_EN.
module dcache_wr_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LINE_W = 128
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       up_wr_req,
  input  logic [2:0]                 up_wr_type,
  input  logic [31:0]                up_wr_addr,
  input  logic [3:0]                 up_wr_wstrb,
  input  logic [LINE_W-1:0]          up_wr_data,
  output logic                       up_wr_rdy,
  input  logic                       up_rd_req,
  input  logic [31:0]                up_rd_addr,
  output logic                       up_rd_rdy,
  output logic                       dn_rd_req,
  input  logic                       dn_rd_rdy,
  output logic                       dn_wr_req,
  output logic [2:0]                 dn_wr_type,
  output logic [31:0]                dn_wr_addr,
  output logic [3:0]                 dn_wr_wstrb,
  output logic [LINE_W-1:0]          dn_wr_data,
  input  logic                       dn_wr_rdy,
  output logic                       wbuf_empty,
  output logic [$clog2(DEPTH):0]     wbuf_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [DEPTH-1:0]  valid;
  logic [2:0]        type_mem  [DEPTH];
  logic [31:0]       addr_mem  [DEPTH];
  logic [3:0]        wstrb_mem [DEPTH];
  logic [LINE_W-1:0] data_mem  [DEPTH];

  logic head_valid, push, pop, bypass_done;
  logic line_hit, push_hit, conflict;
  logic unused_rd_lo;

  assign unused_rd_lo = ^up_rd_addr[3:0];
  assign head_valid   = (count != '0);
  assign up_wr_rdy    = (count != CW'(DEPTH));
  assign wbuf_empty   = ~head_valid;
  assign wbuf_count   = count;

`ifdef WBUF_BYPASS_EN
  logic bypass;
  assign bypass      = ~head_valid & up_wr_req;
  assign bypass_done = bypass & dn_wr_rdy;
`else
  assign bypass_done = 1'b0;
`endif

  // Only a head entry is popped; a bypassed write never enters storage.
  assign pop  = head_valid & dn_wr_rdy;
  assign push = up_wr_req & up_wr_rdy & ~bypass_done;

  always_comb begin
    dn_wr_req   = head_valid;
    dn_wr_type  = head_valid ? type_mem[rd_ptr]  : '0;
    dn_wr_addr  = head_valid ? addr_mem[rd_ptr]  : '0;
    dn_wr_wstrb = head_valid ? wstrb_mem[rd_ptr] : '0;
    dn_wr_data  = head_valid ? data_mem[rd_ptr]  : '0;
`ifdef WBUF_BYPASS_EN
    if (bypass) begin
      dn_wr_req   = 1'b1;
      dn_wr_type  = up_wr_type;
      dn_wr_addr  = up_wr_addr;
      dn_wr_wstrb = up_wr_wstrb;
      dn_wr_data  = up_wr_data;
    end
`endif
  end

  // A popping entry stays valid through its pop cycle, so the read is released one cycle later.
  always_comb begin
    line_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i] && (addr_mem[i][31:4] == up_rd_addr[31:4])) line_hit = 1'b1;
    end
  end

  assign push_hit  = up_wr_req & up_wr_rdy & (up_wr_addr[31:4] == up_rd_addr[31:4]);
  assign conflict  = up_rd_req & (line_hit | push_hit);
  assign dn_rd_req = up_rd_req & ~conflict & ~reset;
  assign up_rd_rdy = dn_rd_rdy & ~conflict & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        type_mem[i]  <= '0;
        addr_mem[i]  <= '0;
        wstrb_mem[i] <= '0;
        data_mem[i]  <= '0;
      end
    end else begin
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PW'(1);
      end
      if (push) begin
        valid[wr_ptr]     <= 1'b1;
        type_mem[wr_ptr]  <= up_wr_type;
        addr_mem[wr_ptr]  <= up_wr_addr;
        wstrb_mem[wr_ptr] <= up_wr_wstrb;
        data_mem[wr_ptr]  <= up_wr_data;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_dcache_wr_buffer.sv
// Self-checking bench for dcache_wr_buffer: scoreboard of expected bridge writes plus
// directed checks of reset, full/empty, read hazard, push+pop and bypass behaviour.
module tb_dcache_wr_buffer;

  typedef struct packed {
    logic [2:0]   wtype;
    logic [31:0]  addr;
    logic [3:0]   wstrb;
    logic [127:0] data;
  } wr_ent_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         up_wr_req = 1'b0;
  logic [2:0]   up_wr_type = '0;
  logic [31:0]  up_wr_addr = '0;
  logic [3:0]   up_wr_wstrb = '0;
  logic [127:0] up_wr_data = '0;
  logic         up_wr_rdy;
  logic         up_rd_req = 1'b0;
  logic [31:0]  up_rd_addr = '0;
  logic         up_rd_rdy;
  logic         dn_rd_req;
  logic         dn_rd_rdy = 1'b0;
  logic         dn_wr_req;
  logic [2:0]   dn_wr_type;
  logic [31:0]  dn_wr_addr;
  logic [3:0]   dn_wr_wstrb;
  logic [127:0] dn_wr_data;
  logic         dn_wr_rdy = 1'b0;
  logic         wbuf_empty;
  logic [2:0]   wbuf_count;

  int n_checks = 0;
  int n_errors = 0;
  wr_ent_t sb[$];

  dcache_wr_buffer #(.DEPTH(4), .LINE_W(128)) dut (
    .clk         (clk),
    .reset       (reset),
    .up_wr_req   (up_wr_req),
    .up_wr_type  (up_wr_type),
    .up_wr_addr  (up_wr_addr),
    .up_wr_wstrb (up_wr_wstrb),
    .up_wr_data  (up_wr_data),
    .up_wr_rdy   (up_wr_rdy),
    .up_rd_req   (up_rd_req),
    .up_rd_addr  (up_rd_addr),
    .up_rd_rdy   (up_rd_rdy),
    .dn_rd_req   (dn_rd_req),
    .dn_rd_rdy   (dn_rd_rdy),
    .dn_wr_req   (dn_wr_req),
    .dn_wr_type  (dn_wr_type),
    .dn_wr_addr  (dn_wr_addr),
    .dn_wr_wstrb (dn_wr_wstrb),
    .dn_wr_data  (dn_wr_data),
    .dn_wr_rdy   (dn_wr_rdy),
    .wbuf_empty  (wbuf_empty),
    .wbuf_count  (wbuf_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Every accepted bridge write must match the oldest outstanding expected entry.
  always @(negedge clk) begin
    if (!reset && dn_wr_req && dn_wr_rdy) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 128'(dn_wr_addr), 128'hFFFF_FFFF);
      end else begin
        wr_ent_t e;
        e = sb.pop_front();
        check("sb_type",  128'(dn_wr_type),  128'(e.wtype));
        check("sb_addr",  128'(dn_wr_addr),  128'(e.addr));
        check("sb_wstrb", 128'(dn_wr_wstrb), 128'(e.wstrb));
        check("sb_data",  dn_wr_data,        e.data);
      end
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic do_write(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                          input logic [127:0] d);
    bit ok = 0;
    up_wr_req = 1'b1; up_wr_type = t; up_wr_addr = a; up_wr_wstrb = s; up_wr_data = d;
    sb.push_back('{wtype: t, addr: a, wstrb: s, data: d});
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (up_wr_rdy) begin ok = 1; break; end
    end
    if (!ok) check("write_accept_timeout", 0, 1);
    @(posedge clk); #1;
    up_wr_req = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (wbuf_empty && !dn_wr_req && sb.size() == 0) begin ok = 1; break; end
    end
    if (!ok) check("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"},     128'(wbuf_count), 0);
    check({tag, "_empty"},     128'(wbuf_empty), 1);
    check({tag, "_dn_wr_req"}, 128'(dn_wr_req),  0);
    check({tag, "_up_wr_rdy"}, 128'(up_wr_rdy),  1);
    check({tag, "_dn_rd_req"}, 128'(dn_rd_req),  0);
    check({tag, "_up_rd_rdy"}, 128'(up_rd_rdy),  0);
    check({tag, "_dn_addr"},   128'(dn_wr_addr), 0);
  endtask

  initial begin
    up_rd_req = 1'b1; up_rd_addr = 32'h1C00_0000; dn_rd_rdy = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state("rst0");
    up_rd_req = 1'b0; dn_rd_rdy = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset mid-traffic discards pending entries
    do_write(3'b100, 32'h1C00_1000, 4'h0, {4{32'h1111_1111}});
    do_write(3'b100, 32'h1C00_1010, 4'h0, {4{32'h2222_2222}});
    @(negedge clk);
    check("pre_rst_count", 128'(wbuf_count), 2);
    #2 reset = 1'b1;
    sb.delete();
    @(negedge clk);
    check_reset_state("rst1");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Fill to full, hold a fifth, then drain back-to-back
    for (int i = 0; i < 4; i++)
      do_write(3'b100, 32'h1C00_0000 + 32'(i * 16), 4'h0, {4{32'(i + 32'hA0)}});
    up_wr_req = 1'b1; up_wr_type = 3'b100; up_wr_addr = 32'h1C00_0040; up_wr_wstrb = '0;
    up_wr_data = {4{32'hA4}};
    sb.push_back('{wtype: 3'b100, addr: 32'h1C00_0040, wstrb: 4'h0, data: {4{32'hA4}}});
    @(negedge clk);
    check("full_count", 128'(wbuf_count), 4);
    check("full_rdy",   128'(up_wr_rdy),  0);
    @(posedge clk); #1;
    @(negedge clk);
    check("held_count", 128'(wbuf_count), 4);
    @(posedge clk); #1;
    dn_wr_rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bit acc;
      @(negedge clk);
      check("drain_req",  128'(dn_wr_req),  1);
      check("drain_addr", 128'(dn_wr_addr), 128'(32'h1C00_0000 + 32'(c * 16)));
      acc = up_wr_req && up_wr_rdy;
      @(posedge clk); #1;
      if (acc) up_wr_req = 1'b0;
    end
    @(negedge clk);
    check("drain_done_req",   128'(dn_wr_req),  0);
    check("drain_done_empty", 128'(wbuf_empty), 1);
    check("drain_held_sent",  128'(sb.size()),  0);
    @(posedge clk); #1;
    dn_wr_rdy = 1'b0;

    // Read hazard against a buffered line and against a same-cycle push
    do_write(3'b100, 32'h1C00_0120, 4'h0, {4{32'hC0DE_0120}});
    up_rd_req = 1'b1; up_rd_addr = 32'h1C00_012C; dn_rd_rdy = 1'b1;
    @(negedge clk);
    check("haz_dn_rd_req", 128'(dn_rd_req), 0);
    check("haz_up_rd_rdy", 128'(up_rd_rdy), 0);
    up_rd_addr = 32'h1C00_0200;
    #1;
    check("nohaz_dn_rd_req", 128'(dn_rd_req), 1);
    check("nohaz_up_rd_rdy", 128'(up_rd_rdy), 1);
    up_rd_addr = 32'h1C00_012C;
    @(posedge clk); #1;
    dn_wr_rdy = 1'b1;
    @(negedge clk);
    check("haz_pop_cycle", 128'(dn_rd_req), 0);
    @(negedge clk);
    check("haz_released",     128'(dn_rd_req), 1);
    check("haz_released_rdy", 128'(up_rd_rdy), 1);
    @(posedge clk); #1;
    dn_wr_rdy = 1'b0;
    up_wr_req = 1'b1; up_wr_type = 3'b100; up_wr_addr = 32'h1C00_0300; up_wr_wstrb = '0;
    up_wr_data = {4{32'h0300}};
    sb.push_back('{wtype: 3'b100, addr: 32'h1C00_0300, wstrb: 4'h0, data: {4{32'h0300}}});
    up_rd_addr = 32'h1C00_0304;
    @(negedge clk);
    check("haz_push_same_cycle", 128'(dn_rd_req), 0);
    @(posedge clk); #1;
    up_wr_req = 1'b0; up_rd_req = 1'b0; dn_rd_rdy = 1'b0;
    dn_wr_rdy = 1'b1;
    wait_drain();
    dn_wr_rdy = 1'b0;

    // Simultaneous push and pop at count=2
    do_write(3'b100, 32'h1C00_0400, 4'h0, {4{32'hAAAA_AAAA}});
    do_write(3'b100, 32'h1C00_0410, 4'h0, {4{32'hBBBB_BBBB}});
    up_wr_req = 1'b1; up_wr_type = 3'b100; up_wr_addr = 32'h1C00_0420; up_wr_wstrb = '0;
    up_wr_data = {4{32'hCCCC_CCCC}};
    sb.push_back('{wtype: 3'b100, addr: 32'h1C00_0420, wstrb: 4'h0, data: {4{32'hCCCC_CCCC}}});
    dn_wr_rdy = 1'b1;
    @(negedge clk);
    check("pp_count_before", 128'(wbuf_count), 2);
    @(posedge clk); #1;
    up_wr_req = 1'b0;
    @(negedge clk);
    check("pp_count_after", 128'(wbuf_count), 2);
    check("pp_head_data",   dn_wr_data, {4{32'hBBBB_BBBB}});
    @(posedge clk); #1;
    wait_drain();
    dn_wr_rdy = 1'b0;

    // Uncached word write queued behind a line write
    do_write(3'b100, 32'h1C00_0500, 4'h0, {4{32'h5555_0500}});
    do_write(3'b010, 32'hBFAF_0000, 4'b0011, 128'h1234_5678);
    @(negedge clk);
    check("word_count", 128'(wbuf_count), 2);
    @(posedge clk); #1;
    dn_wr_rdy = 1'b1;
    wait_drain();

    // Write latency from empty (bypass when built with WBUF_BYPASS_EN)
    up_wr_req = 1'b1; up_wr_type = 3'b100; up_wr_addr = 32'h1C00_0040; up_wr_wstrb = '0;
    up_wr_data = {4{32'h4040_4040}};
    sb.push_back('{wtype: 3'b100, addr: 32'h1C00_0040, wstrb: 4'h0, data: {4{32'h4040_4040}}});
    @(negedge clk);
`ifdef WBUF_BYPASS_EN
    check("lat_same_cycle_req", 128'(dn_wr_req), 1);
`else
    check("lat_same_cycle_req", 128'(dn_wr_req), 0);
`endif
    @(posedge clk); #1;
    up_wr_req = 1'b0;
    @(negedge clk);
`ifdef WBUF_BYPASS_EN
    check("lat_next_count", 128'(wbuf_count), 0);
    check("lat_next_req",   128'(dn_wr_req),  0);
`else
    check("lat_next_count", 128'(wbuf_count), 1);
    check("lat_next_req",   128'(dn_wr_req),  1);
    check("lat_next_addr",  128'(dn_wr_addr), 128'(32'h1C00_0040));
`endif
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_final_count", 128'(wbuf_count), 0);
    check("sb_all_written",  128'(sb.size()),  0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
